// File: rtl/hqm_system_flr_pkg.sv
// Shared definitions for the FLR prep controller.
//   flr_state_e  : sequencing states of the prep FSM
//   ERR_*        : bit positions inside err_status
//   cnt_w()      : width of an outstanding counter able to hold 0..depth
package hqm_system_flr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ISOLATE  = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_REL = 3'd4
  } flr_state_e;

  localparam int ERR_W       = 3;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVF     = 1;
  localparam int ERR_UNF     = 2;

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hqm_system_flr_outstanding_cnt.sv
// Outstanding-entry counter for one posted FIFO.
//   clk_i, rst_i  : clock, async active-high reset
//   push_i        : qualified (already isolation-masked) push
//   pop_i         : pop
//   count_o       : registered outstanding count, 0..DEPTH
//   overflow_o    : push-only while full this cycle (count held)
//   underflow_o   : pop-only while empty this cycle (count held)
module hqm_system_flr_outstanding_cnt
  import hqm_system_flr_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int W = cnt_w(DEPTH);
  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic [W-1:0] cnt_q, cnt_d;

  // Push and pop together cancel, so neither error can fire then.
  always_comb begin
    cnt_d       = cnt_q;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (push_i && !pop_i) begin
      if (cnt_q == FULL) overflow_o = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !push_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hqm_system_flr_prep_ctl.sv
// FLR prep controller: stalls ingress, waits for the posted FIFOs to drain
// (or a timeout), holds isolation for a programmable time, pulses flr_done
// and keeps isolation until the request is released.
//   hqm_gated_clk / hqm_gated_rst : clock, async active-high reset
//   flr_req                       : level request for FLR prep
//   cfg_quiesce_timeout           : drain timeout in cycles, 0 = none
//   cfg_hold_cycles               : isolation hold before flr_done (n+1 cycles)
//   p{hdr,data}_fifo_push/pop     : raw FIFO push / pop
//   err_clr                       : clear sticky errors
//   ingress_stall, flr_prep, flr_done : registered control outputs
//   hdr_cnt, data_cnt             : outstanding counts
//   err_status                    : sticky {underflow, overflow, timeout}
module hqm_system_flr_prep_ctl
  import hqm_system_flr_pkg::*;
#(
  parameter int HDR_DEPTH  = 32,
  parameter int DATA_DEPTH = 64
) (
  input  logic                           hqm_gated_clk,
  input  logic                           hqm_gated_rst,
  input  logic                           flr_req,
  input  logic [15:0]                    cfg_quiesce_timeout,
  input  logic [7:0]                     cfg_hold_cycles,
  input  logic                           phdr_fifo_push,
  input  logic                           pdata_fifo_push,
  input  logic                           phdr_fifo_pop,
  input  logic                           pdata_fifo_pop,
  input  logic                           err_clr,
  output logic                           ingress_stall,
  output logic                           flr_prep,
  output logic                           flr_done,
  output logic [cnt_w(HDR_DEPTH)-1:0]    hdr_cnt,
  output logic [cnt_w(DATA_DEPTH)-1:0]   data_cnt,
  output logic [ERR_W-1:0]               err_status
);

  flr_state_e       state_q, state_d;
  logic [15:0]      timer_q, timer_d, timer_plus;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       hold_q, hold_d, hcnt_q, hcnt_d;
  logic             tmo_err;
  logic             drained;
  logic             stall_d, prep_d, done_d;
  logic [ERR_W-1:0] err_set, err_d;
  logic             hdr_ovf, hdr_unf, data_ovf, data_unf;

  // flr_prep is the flop driving the external isolation cells; using it to
  // mask pushes keeps the counters consistent with what the FIFOs see.
  hqm_system_flr_outstanding_cnt #(.DEPTH(HDR_DEPTH)) u_hdr_cnt (
    .clk_i       (hqm_gated_clk),
    .rst_i       (hqm_gated_rst),
    .push_i      (phdr_fifo_push & ~flr_prep),
    .pop_i       (phdr_fifo_pop),
    .count_o     (hdr_cnt),
    .overflow_o  (hdr_ovf),
    .underflow_o (hdr_unf)
  );

  hqm_system_flr_outstanding_cnt #(.DEPTH(DATA_DEPTH)) u_data_cnt (
    .clk_i       (hqm_gated_clk),
    .rst_i       (hqm_gated_rst),
    .push_i      (pdata_fifo_push & ~flr_prep),
    .pop_i       (pdata_fifo_pop),
    .count_o     (data_cnt),
    .overflow_o  (data_ovf),
    .underflow_o (data_unf)
  );

  assign drained    = (hdr_cnt == '0) && (data_cnt == '0);
  assign timer_plus = timer_q + 16'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    tmo_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flr_req) begin
          state_d = ST_DRAIN;
          tmo_d   = cfg_quiesce_timeout;
          hold_d  = cfg_hold_cycles;
          timer_d = '0;
        end
      end
      ST_DRAIN: begin
        timer_d = timer_plus;
        // Abort beats both exits; a drained FIFO pair beats the timeout.
        if (!flr_req) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (drained) begin
          state_d = ST_ISOLATE;
          hcnt_d  = '0;
        end else if ((tmo_q != '0) && (timer_plus == tmo_q)) begin
          state_d = ST_ISOLATE;
          hcnt_d  = '0;
          tmo_err = 1'b1;
        end
      end
      ST_ISOLATE: begin
        if (hcnt_q == hold_q) state_d = ST_DONE;
        else                  hcnt_d  = hcnt_q + 8'd1;
      end
      ST_DONE:     state_d = ST_WAIT_REL;
      ST_WAIT_REL: if (!flr_req) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are flops loaded from the next-state decode, so they line up
  // with state_q without any combinational path to the pins.
  assign stall_d = (state_d != ST_IDLE);
  assign prep_d  = (state_d == ST_ISOLATE) || (state_d == ST_DONE) ||
                   (state_d == ST_WAIT_REL);
  assign done_d  = (state_d == ST_DONE);

  always_comb begin
    err_set              = '0;
    err_set[ERR_TIMEOUT] = tmo_err;
    err_set[ERR_OVF]     = hdr_ovf | data_ovf;
    err_set[ERR_UNF]     = hdr_unf | data_unf;
  end

  // A new error event in the clear cycle survives the clear.
  assign err_d = (err_clr ? '0 : err_status) | err_set;

  always_ff @(posedge hqm_gated_clk or posedge hqm_gated_rst) begin
    if (hqm_gated_rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      tmo_q         <= '0;
      hold_q        <= '0;
      hcnt_q        <= '0;
      ingress_stall <= 1'b0;
      flr_prep      <= 1'b0;
      flr_done      <= 1'b0;
      err_status    <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      tmo_q         <= tmo_d;
      hold_q        <= hold_d;
      hcnt_q        <= hcnt_d;
      ingress_stall <= stall_d;
      flr_prep      <= prep_d;
      flr_done      <= done_d;
      err_status    <= err_d;
    end
  end

endmodule

// File: tb/tb_hqm_system_flr_prep_ctl.sv
module tb_hqm_system_flr_prep_ctl;

  localparam int HD = 32;
  localparam int DD = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] tmo = '0;
  logic [7:0]  hold = '0;
  logic        ph = 1'b0, dh = 1'b0, pp = 1'b0, dp = 1'b0, clr = 1'b0;
  logic        ingress_stall, flr_prep, flr_done;
  logic [5:0]  hdr_cnt;
  logic [6:0]  data_cnt;
  logic [2:0]  err_status;

  always #5 clk = ~clk;

  hqm_system_flr_prep_ctl #(.HDR_DEPTH(HD), .DATA_DEPTH(DD)) dut (
    .hqm_gated_clk       (clk),
    .hqm_gated_rst       (rst),
    .flr_req             (req),
    .cfg_quiesce_timeout (tmo),
    .cfg_hold_cycles     (hold),
    .phdr_fifo_push      (ph),
    .pdata_fifo_push     (dh),
    .phdr_fifo_pop       (pp),
    .pdata_fifo_pop      (dp),
    .err_clr             (clr),
    .ingress_stall       (ingress_stall),
    .flr_prep            (flr_prep),
    .flr_done            (flr_done),
    .hdr_cnt             (hdr_cnt),
    .data_cnt            (data_cnt),
    .err_status          (err_status)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs();
    return {13'b0, hdr_cnt, data_cnt, err_status, ingress_stall, flr_prep, flr_done};
  endfunction

  function automatic logic [31:0] expv(input int h, input int d, input logic [2:0] e,
                                       input logic s, input logic p, input logic dn);
    return {13'b0, 6'(h), 7'(d), e, s, p, dn};
  endfunction

  task automatic quiet();
    req = 0; ph = 0; dh = 0; pp = 0; dp = 0; clr = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Wait (bounded) until the block is back in idle with stall low.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (ingress_stall && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_idle_reached"}, {31'b0, ingress_stall}, 32'd0);
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase: 0 idle, 1 drain, 2 isolate, 3 done pulse, 4 waiting for release.
  int          m_h, m_d, m_ph, m_spent, m_left, m_tmo, m_hold;
  logic [2:0]  m_err;

  task automatic model_reset();
    m_h = 0; m_d = 0; m_ph = 0; m_spent = 0; m_left = 0; m_tmo = 0; m_hold = 0;
    m_err = '0;
  endtask

  task automatic model_step();
    logic       prep, hp, dpq;
    logic [2:0] set;
    int         nh, nd, nph;
    prep = (m_ph >= 2);
    set  = '0;
    nh = m_h; nd = m_d; nph = m_ph;
    hp  = ph & ~prep;
    dpq = dh & ~prep;
    if (hp && !pp)       begin if (m_h == HD) set[1] = 1; else nh = m_h + 1; end
    else if (pp && !hp)  begin if (m_h == 0)  set[2] = 1; else nh = m_h - 1; end
    if (dpq && !dp)      begin if (m_d == DD) set[1] = 1; else nd = m_d + 1; end
    else if (dp && !dpq) begin if (m_d == 0)  set[2] = 1; else nd = m_d - 1; end
    case (m_ph)
      0: if (req) begin nph = 1; m_tmo = int'(tmo); m_hold = int'(hold); m_spent = 0; end
      1: begin
        m_spent++;
        if (!req) begin nph = 0; m_spent = 0; end
        else if (m_h == 0 && m_d == 0) begin nph = 2; m_left = m_hold + 1; end
        else if (m_tmo != 0 && m_spent == m_tmo) begin nph = 2; m_left = m_hold + 1; set[0] = 1; end
      end
      2: begin m_left--; if (m_left == 0) nph = 3; end
      3: nph = 4;
      default: if (!req) nph = 0;
    endcase
    m_err = (clr ? 3'b000 : m_err) | set;
    m_h = nh; m_d = nd; m_ph = nph;
  endtask

  function automatic logic [31:0] model_exp();
    return expv(m_h, m_d, m_err, m_ph != 0, m_ph >= 2, m_ph == 3);
  endfunction

  // ---------------- counter vector table ----------------
  typedef struct {
    logic       ph, pp, dh, dp, clr;
    int         eh, ed;
    logic [2:0] ee;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int iso, n;
    logic seen, prep_seen;

    tbl[0]  = '{1,0,0,0,0, 1,0,3'b000};
    tbl[1]  = '{1,0,1,0,0, 2,1,3'b000};
    tbl[2]  = '{1,0,1,0,0, 3,2,3'b000};
    tbl[3]  = '{1,1,0,0,0, 3,2,3'b000};
    tbl[4]  = '{0,1,0,1,0, 2,1,3'b000};
    tbl[5]  = '{0,0,0,1,0, 2,0,3'b000};
    tbl[6]  = '{0,0,0,1,0, 2,0,3'b100};
    tbl[7]  = '{0,0,0,0,1, 2,0,3'b000};
    tbl[8]  = '{0,0,0,1,1, 2,0,3'b100};
    tbl[9]  = '{0,0,0,0,1, 2,0,3'b000};
    tbl[10] = '{0,1,0,0,0, 1,0,3'b000};
    tbl[11] = '{0,1,0,0,0, 0,0,3'b000};
    tbl[12] = '{0,1,0,0,0, 0,0,3'b100};
    tbl[13] = '{0,0,0,0,1, 0,0,3'b000};

    // reset state
    quiet();
    tick();
    chk("reset_state", obs(), 32'd0);
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      ph = tbl[i].ph; pp = tbl[i].pp; dh = tbl[i].dh; dp = tbl[i].dp; clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i), obs(), expv(tbl[i].eh, tbl[i].ed, tbl[i].ee, 0, 0, 0));
    end
    quiet();

    // push+pop at 4 holds; fill to 32; 33rd push overflows and holds
    do_reset();
    ph = 1;
    repeat (4) tick();
    pp = 1;
    tick();
    chk("pushpop_at4", obs(), expv(4, 0, 0, 0, 0, 0));
    pp = 0;
    repeat (28) tick();
    chk("fill_32", obs(), expv(32, 0, 0, 0, 0, 0));
    tick();
    chk("ovf_33rd", obs(), expv(32, 0, 3'b010, 0, 0, 0));
    quiet();

    // drain waits for pops, 3 isolate cycles, single flr_done
    do_reset();
    ph = 1; dh = 1;
    repeat (3) tick();
    ph = 0;
    repeat (2) tick();
    dh = 0;
    req = 1; hold = 8'd2; tmo = 16'd0;
    tick();
    chk("s1_drain_entry", obs(), expv(3, 5, 0, 1, 0, 0));
    repeat (2) tick();
    chk("s1_drain_held", obs(), expv(3, 5, 0, 1, 0, 0));
    pp = 1; dp = 1;
    repeat (3) tick();
    pp = 0;
    repeat (2) tick();
    dp = 0;
    chk("s1_drained_still_drain", obs(), expv(0, 0, 0, 1, 0, 0));
    iso = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (flr_done) begin seen = 1; break; end
      if (flr_prep) iso++;
    end
    chk("s1_done_seen", {31'b0, seen}, 32'd1);
    chk("s1_iso_cycles", iso, 3);
    chk("s1_done_cycle", obs(), expv(0, 0, 0, 1, 1, 1));
    tick();
    chk("s1_wait_rel", obs(), expv(0, 0, 0, 1, 1, 0));
    req = 0;
    tick();
    chk("s1_release", obs(), expv(0, 0, 0, 0, 0, 0));

    // empty FIFOs: isolate on cycle 2, pushes masked while isolated
    do_reset();
    req = 1; hold = 8'd4;
    tick();
    chk("s2_cycle1", obs(), expv(0, 0, 0, 1, 0, 0));
    tick();
    chk("s2_cycle2", obs(), expv(0, 0, 0, 1, 1, 0));
    ph = 1; dh = 1;
    tick();
    chk("s2_masked_push", obs(), expv(0, 0, 0, 1, 1, 0));
    quiet();
    wait_idle("s2");

    // timeout after 10 drain cycles
    do_reset();
    ph = 1;
    tick();
    ph = 0;
    req = 1; tmo = 16'd10; hold = 8'd0;
    tick();
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (flr_prep) break;
      n++;
    end
    chk("s3_drain_cycles", n, 10);
    chk("s3_err", {29'b0, err_status}, 32'd1);
    chk("s3_hdr", {26'b0, hdr_cnt}, 32'd1);
    req = 0;
    wait_idle("s3");
    chk("s3_err_sticky", {29'b0, err_status}, 32'd1);
    clr = 1;
    tick();
    clr = 0;
    chk("s3_err_clr", {29'b0, err_status}, 32'd0);

    // abort in drain
    do_reset();
    ph = 1;
    tick();
    ph = 0;
    req = 1; tmo = 16'd0;
    prep_seen = 0;
    tick(); prep_seen |= flr_prep;
    tick(); prep_seen |= flr_prep;
    req = 0;
    tick(); prep_seen |= flr_prep;
    chk("s5_abort_idle", obs(), expv(1, 0, 0, 0, 0, 0));
    chk("s5_no_prep", {31'b0, prep_seen}, 32'd0);

    // drop in isolate: sequence completes, exits via wait_rel
    pp = 1;
    tick();
    pp = 0;
    req = 1; hold = 8'd3;
    tick();
    tick();
    chk("s5b_isolate", obs(), expv(0, 0, 0, 1, 1, 0));
    req = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (flr_done) begin seen = 1; break; end
    end
    chk("s5b_done_seen", {31'b0, seen}, 32'd1);
    tick();
    chk("s5b_wait_rel", obs(), expv(0, 0, 0, 1, 1, 0));
    tick();
    chk("s5b_idle", obs(), expv(0, 0, 0, 0, 0, 0));

    // async reset in isolate
    do_reset();
    ph = 1; dh = 1;
    tick();
    quiet();
    req = 1; tmo = 16'd3; hold = 8'd5;
    for (int i = 0; i < 20 && !flr_prep; i++) tick();
    chk("s6_in_isolate", {31'b0, flr_prep}, 32'd1);
    rst = 1;
    #1;
    chk("s6_async_reset", obs(), 32'd0);
    req = 0;
    tick();
    rst = 0;
    tick();
    chk("s6_after_release", obs(), 32'd0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int bias;
      bias = ((c / 400) % 2 == 1) ? 65 : 35;
      if ($urandom_range(0, 19) == 0) req = ~req;
      ph   = ($urandom_range(0, 99) < bias);
      dh   = ($urandom_range(0, 99) < bias);
      pp   = ($urandom_range(0, 99) < (100 - bias));
      dp   = ($urandom_range(0, 99) < (100 - bias));
      clr  = ($urandom_range(0, 15) == 0);
      tmo  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 25));
      hold = 8'($urandom_range(0, 6));
      model_step();
      tick();
      chk($sformatf("rand_c%0d", c), obs(), model_exp());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hqm_system_flr_prep_ctl.md
HQM_SYSTEM_FLR_PREP_CTL -- requirements
Module: hqm_system_flr_prep_ctl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters, one per line: name, default, meaning.
- HDR_DEPTH, 32, posted-header FIFO depth.
- DATA_DEPTH, 64, posted-data FIFO depth.
REQ-003 Ports, one per line: name, direction, width, meaning.
- hqm_gated_clk, in, 1, sole clock.
- hqm_gated_rst, in, 1, asynchronous active-high reset.
- flr_req, in, 1, level request to enter FLR prep.
- cfg_quiesce_timeout, in, 16, drain timeout in cycles; 0 = no timeout.
- cfg_hold_cycles, in, 8, cycles to hold isolation before flr_done.
- phdr_fifo_push / pdata_fifo_push, in, 1 each, raw (pre-isolation) push.
- phdr_fifo_pop / pdata_fifo_pop, in, 1 each, FIFO pop.
- err_clr, in, 1, clears sticky error bits.
- ingress_stall, out, 1, blocks new posted requests upstream.
- flr_prep, out, 1, drives the isolation cells on proc_clk_en and the phdr/pdata push signals.
- flr_done, out, 1, one-cycle completion pulse.
- hdr_cnt, out, clog2(HDR_DEPTH)+1, outstanding headers.
- data_cnt, out, clog2(DATA_DEPTH)+1, outstanding data beats.
- err_status, out, 3, sticky bits: [0] drain timeout, [1] overflow, [2] underflow.

Function
REQ-004 SHALL qualify each push as push & ~flr_prep; an isolated push SHALL NOT change a counter.
REQ-005 SHALL update each counter per cycle:
- qualified push only: +1.
- pop only: -1.
- qualified push and pop together: unchanged.
REQ-006 A qualified push at count == DEPTH SHALL hold the count and set err_status[1].
REQ-007 A pop at count == 0 SHALL hold the count at 0 and set err_status[2].
REQ-008 SHALL implement FSM states IDLE, DRAIN, ISOLATE, DONE and WAIT_REL.
REQ-009 IDLE: all outputs low; flr_req==1 SHALL transition to DRAIN on the next edge.
REQ-010 DRAIN: ingress_stall=1, drain timer increments each cycle.
- SHALL go to ISOLATE when hdr_cnt==0 and data_cnt==0.
- Otherwise SHALL go to ISOLATE when cfg_quiesce_timeout!=0 and the timer reaches cfg_quiesce_timeout, also setting err_status[0].
- If both conditions hold in the same cycle, the drained exit wins and err_status[0] is not set.
REQ-011 ISOLATE: flr_prep=1, ingress_stall=1; SHALL hold for cfg_hold_cycles+1 cycles (0 gives 1 cycle), then go to DONE.
REQ-012 DONE: flr_done=1 for exactly one cycle, flr_prep=1; SHALL go to WAIT_REL.
REQ-013 WAIT_REL: flr_prep=1, ingress_stall=1 until flr_req==0, then IDLE; flr_prep SHALL deassert in the first IDLE cycle.
REQ-014 flr_req deasserted during DRAIN SHALL abort to IDLE, clear the timer and never assert flr_prep.
REQ-015 flr_req deasserted during ISOLATE or DONE SHALL NOT abort; the sequence SHALL complete, then exit via WAIT_REL.
REQ-016 Config inputs SHALL be sampled on IDLE->DRAIN and held constant for the sequence.
REQ-017 err_clr SHALL clear err_status in the next cycle; a simultaneous set event SHALL win.
REQ-018 All outputs SHALL be registered; flr_prep SHALL be a direct flop output with no glitching.

Reset
REQ-019 Asserting hqm_gated_rst SHALL asynchronously force IDLE and zero all outputs, counters, timers and sampled config.
REQ-020 Reset mid-sequence SHALL drop flr_prep immediately with no flr_done.
REQ-021 After reset release, the first FSM transition SHALL occur on the first rising edge.

Structure
REQ-022 FSM state enum, err_status bit indices and counter-width localparam functions SHALL live in shared package hqm_system_flr_pkg.
REQ-023 The two outstanding counters SHALL be two instances of sub-module hqm_system_flr_outstanding_cnt (parameter DEPTH), each providing count, overflow and underflow.
REQ-024 Isolation cells SHALL remain external; this block only drives flr_prep.

Verification
REQ-025 Directed scenarios:
- 3 headers and 5 data beats pushed, flr_req=1, cfg_hold_cycles=2 -> stays in DRAIN until all pops; flr_prep high for 3 cycles before the one-cycle flr_done.
- Counters 0, flr_req=1 -> ISOLATE on cycle 2; push during flr_prep=1 -> counts unchanged.
- 1 header never popped, cfg_quiesce_timeout=10 -> ISOLATE after 10 DRAIN cycles, err_status=3'b001.
- Simultaneous push and pop at hdr_cnt=4 -> stays 4; pop at 0 -> err_status[2]=1; 33rd push with HDR_DEPTH=32 -> err_status[1]=1, count 32.
- flr_req dropped in DRAIN -> IDLE, flr_prep never high; dropped in ISOLATE -> sequence completes, flr_done pulses.
- hqm_gated_rst asserted in ISOLATE -> flr_prep=0 the same cycle, all counters 0.
